// File: rtl/router_pkg.sv
// Shared definitions for the three-port packet router.
// Holds the router FSM state type, the header address codes, the port count
// and the default values of the top-level parameters.
package router_pkg;

    localparam int NUM_PORTS           = 3;
    localparam int DEF_FIFO_DEPTH      = 16;
    localparam int DEF_SOFT_RST_CYCLES = 30;

    localparam logic [1:0] ADDR_PORT0   = 2'd0;
    localparam logic [1:0] ADDR_PORT1   = 2'd1;
    localparam logic [1:0] ADDR_PORT2   = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY
    } state_t;

endpackage

// File: rtl/router_fifo.sv
// One router output queue: DEPTH x 8 storage, registered read port and an
// idle timer that flushes the queue when nobody reads it for too long.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write strobe and byte (ignored when full)
//   rd_en           consumer read strobe (ignored when empty)
//   rd_data         registered head byte, loaded one edge after a read
//   empty, full     queue status from wrap-bit pointers
//   soft_flush      high in the cycle whose edge flushes the queue
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH           = DEF_FIFO_DEPTH,
    parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       soft_flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SOFT_RST_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_RELOAD = CW'(SOFT_RST_CYCLES - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] idle_cnt;
    logic          idle;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Idle = data waiting but not being read. The timer counts down from
    // SOFT_RST_CYCLES-1 so the flush lands on the SOFT_RST_CYCLES-th idle cycle.
    assign idle       = !empty && !rd_en;
    assign soft_flush = idle && (idle_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idle_cnt <= IDLE_RELOAD;
            rd_data  <= '0;
        end else begin
            if (do_rd) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
            if (soft_flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                idle_cnt <= IDLE_RELOAD;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_rd) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (idle) begin
                    idle_cnt <= idle_cnt - 1'b1;
                end else begin
                    idle_cnt <= IDLE_RELOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !soft_flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/router_top.sv
// Three-port packet router. Packets arrive as {len[7:2], addr[1:0]} header,
// len payload bytes and an XOR parity byte; the whole packet is copied into
// the output queue chosen by addr and the parity is checked on the way.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   pkt_valid, data_in          byte stream, pkt_valid low on the parity byte
//   read_en_0/1/2               consumer read strobes
//   data_out_0/1/2              registered read data per port
//   valid_out_0/1/2             port queue non-empty
//   busy                        source must hold data_in
//   err                         parity mismatch on the last packet
//
// state           | meaning
// DECODE          | idle, waiting for a header with a valid address
// WAIT_TILL_EMPTY | header latched, target queue still holds an older packet
// LOAD_FIRST      | write latched header, restart running parity
// LOAD_DATA       | stream payload, parity byte ends the packet
// FIFO_FULL       | target full, incoming byte parked in the hold register
// LOAD_AFTER_FULL | write the parked byte once space frees up
// CHECK_PARITY    | compare running and received parity into err
module router_top
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       read_en_0,
    input  logic       read_en_1,
    input  logic       read_en_2,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2,
    output logic       busy,
    output logic       err
);

    state_t               state;
    logic [7:0]           hdr_q;
    logic [1:0]           addr_q;
    logic [7:0]           hold_q;
    logic                 hold_pay_q;
    logic [7:0]           parity_q;
    logic [7:0]           rx_parity_q;
    logic                 drop_q;

    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] rd_en;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_flush;
    logic [7:0]           fifo_dout [NUM_PORTS];
    logic                 wr_req;
    logic [7:0]           wr_byte;
    logic                 tgt_empty;
    logic                 tgt_full;
    logic                 tgt_flush;
    logic                 in_empty;

    assign rd_en = {read_en_2, read_en_1, read_en_0};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_fifo #(
            .DEPTH          (FIFO_DEPTH),
            .SOFT_RST_CYCLES(SOFT_RST_CYCLES)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en[i]),
            .wr_data   (wr_byte),
            .rd_en     (rd_en[i]),
            .rd_data   (fifo_dout[i]),
            .empty     (fifo_empty[i]),
            .full      (fifo_full[i]),
            .soft_flush(fifo_flush[i])
        );
    end

    assign data_out_0  = fifo_dout[0];
    assign data_out_1  = fifo_dout[1];
    assign data_out_2  = fifo_dout[2];
    assign valid_out_0 = !fifo_empty[0];
    assign valid_out_1 = !fifo_empty[1];
    assign valid_out_2 = !fifo_empty[2];

    // Status of the latched target and of the port named by an incoming header.
    always_comb begin
        tgt_empty = fifo_empty[2];
        tgt_full  = fifo_full[2];
        tgt_flush = fifo_flush[2];
        case (addr_q)
            ADDR_PORT0: begin
                tgt_empty = fifo_empty[0];
                tgt_full  = fifo_full[0];
                tgt_flush = fifo_flush[0];
            end
            ADDR_PORT1: begin
                tgt_empty = fifo_empty[1];
                tgt_full  = fifo_full[1];
                tgt_flush = fifo_flush[1];
            end
            default: ;
        endcase
        case (data_in[1:0])
            ADDR_PORT0: in_empty = fifo_empty[0];
            ADDR_PORT1: in_empty = fifo_empty[1];
            ADDR_PORT2: in_empty = fifo_empty[2];
            default:    in_empty = 1'b0;
        endcase
    end

    always_comb begin
        wr_req  = 1'b0;
        wr_byte = data_in;
        case (state)
            LOAD_FIRST: begin
                wr_req  = 1'b1;
                wr_byte = hdr_q;
            end
            LOAD_DATA:  wr_req = !tgt_full;
            LOAD_AFTER_FULL: begin
                wr_req  = 1'b1;
                wr_byte = hold_q;
            end
            default: ;
        endcase
        wr_en = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wr_en[i] = wr_req && (addr_q == 2'(i));
        end
    end

    // A flush of the target mid-packet abandons it. drop_q then swallows the
    // remaining bytes up to the parity byte so they are not taken as headers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DECODE;
            busy        <= 1'b0;
            err         <= 1'b0;
            hdr_q       <= '0;
            addr_q      <= '0;
            hold_q      <= '0;
            hold_pay_q  <= 1'b0;
            parity_q    <= '0;
            rx_parity_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            case (state)
                DECODE: begin
                    if (drop_q) begin
                        if (!pkt_valid) drop_q <= 1'b0;
                    end else if (pkt_valid && (data_in[1:0] != ADDR_INVALID)) begin
                        hdr_q  <= data_in;
                        addr_q <= data_in[1:0];
                        busy   <= 1'b1;
                        state  <= in_empty ? LOAD_FIRST : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (tgt_empty) state <= LOAD_FIRST;
                end
                LOAD_FIRST: begin
                    err      <= 1'b0;
                    parity_q <= hdr_q;
                    busy     <= 1'b0;
                    state    <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (tgt_flush) begin
                        drop_q <= pkt_valid;
                        state  <= DECODE;
                    end else if (tgt_full) begin
                        hold_q     <= data_in;
                        hold_pay_q <= pkt_valid;
                        busy       <= 1'b1;
                        state      <= FIFO_FULL;
                    end else if (pkt_valid) begin
                        parity_q <= parity_q ^ data_in;
                    end else begin
                        rx_parity_q <= data_in;
                        busy        <= 1'b1;
                        state       <= CHECK_PARITY;
                    end
                end
                FIFO_FULL: begin
                    if (tgt_flush) begin
                        drop_q <= hold_pay_q;
                        busy   <= 1'b0;
                        state  <= DECODE;
                    end else if (!tgt_full) begin
                        state <= LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (tgt_flush) begin
                        drop_q <= hold_pay_q;
                        busy   <= 1'b0;
                        state  <= DECODE;
                    end else if (hold_pay_q) begin
                        parity_q <= parity_q ^ hold_q;
                        busy     <= 1'b0;
                        state    <= LOAD_DATA;
                    end else begin
                        rx_parity_q <= hold_q;
                        state       <= CHECK_PARITY;
                    end
                end
                CHECK_PARITY: begin
                    err   <= (parity_q != rx_parity_q);
                    busy  <= 1'b0;
                    state <= DECODE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= DECODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_top.sv
// Directed bench for router_top. Packets are built by the bench, which also
// queues the bytes each port must deliver; one compare process checks every
// read result and that data_out holds when nothing is read.
module tb_router_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       read_en_0, read_en_1, read_en_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       valid_out_0, valid_out_1, valid_out_2;
    logic       busy;
    logic       err;

    router_top dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .read_en_0  (read_en_0),
        .read_en_1  (read_en_1),
        .read_en_2  (read_en_2),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .valid_out_0(valid_out_0),
        .valid_out_1(valid_out_1),
        .valid_out_2(valid_out_2),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [3][$];
    logic [7:0] tx_q [$];
    logic [7:0] last_out [3];
    logic       prev_rd [3];
    logic [7:0] cmp_dv;
    int         hi, run, maxrun;

    function automatic logic [7:0] dout(input int p);
        case (p)
            0:       return data_out_0;
            1:       return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    function automatic logic vout(input int p);
        case (p)
            0:       return valid_out_0;
            1:       return valid_out_1;
            default: return valid_out_2;
        endcase
    endfunction

    function automatic logic ren(input int p);
        case (p)
            0:       return read_en_0;
            1:       return read_en_1;
            default: return read_en_2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Header, len payload bytes (first, first+1, ...), XOR parity.
    task automatic build_pkt(input int len, input int addr, input logic [7:0] first,
                             input bit corrupt);
        logic [7:0] par;
        logic [7:0] b;
        tx_q.delete();
        b = 8'((len << 2) | addr);
        tx_q.push_back(b);
        par = b;
        for (int k = 0; k < len; k++) begin
            b = first + 8'(k);
            tx_q.push_back(b);
            par = par ^ b;
        end
        if (corrupt) par = par ^ 8'h01;
        tx_q.push_back(par);
        if (addr < 3) begin
            foreach (tx_q[i]) exp_q[addr].push_back(tx_q[i]);
        end
    endtask

    // Source: a byte is taken at the edge closing a cycle in which busy was low.
    task automatic send_tx();
        logic acc;
        int   guard;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk);
            data_in   = tx_q[i];
            pkt_valid = (i != tx_q.size() - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                acc = !busy;
                @(posedge clk);
                if (!acc) begin
                    guard++;
                    if (guard > 300) begin
                        fail_msg("send_tx busy timeout");
                        pkt_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        data_in   = 8'h00;
    endtask

    task automatic wait_valid(input int p);
        int g;
        for (g = 0; g < 200; g++) begin
            @(negedge clk);
            if (vout(p)) break;
        end
        if (g >= 200) fail_msg($sformatf("wait valid_out_%0d timeout", p));
    endtask

    task automatic wait_drained(input int p);
        for (int g = 0; g < 400; g++) begin
            if (exp_q[p].size() == 0) return;
            @(negedge clk);
        end
        fail_msg($sformatf("drain port %0d: %0d bytes left, expected 0", p, exp_q[p].size()));
    endtask

    // Compare process: a read issued with data available shows up on data_out
    // after the next edge; otherwise data_out must hold.
    initial begin
        for (int p = 0; p < 3; p++) begin
            last_out[p] = 8'h00;
            prev_rd[p]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                for (int p = 0; p < 3; p++) begin
                    last_out[p] = 8'h00;
                    prev_rd[p]  = 1'b0;
                    exp_q[p].delete();
                end
            end else begin
                for (int p = 0; p < 3; p++) begin
                    cmp_dv = dout(p);
                    if (prev_rd[p]) begin
                        if (exp_q[p].size() == 0) begin
                            fail_msg($sformatf("port %0d read data 0x%0h, expected no data", p, cmp_dv));
                        end else begin
                            last_out[p] = exp_q[p].pop_front();
                            check($sformatf("port %0d read data", p), cmp_dv, last_out[p]);
                        end
                    end else begin
                        check($sformatf("port %0d data_out hold", p), cmp_dv, last_out[p]);
                    end
                    prev_rd[p] = ren(p) && vout(p);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        read_en_0 = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset valid_out", {valid_out_2, valid_out_1, valid_out_0}, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        check("reset data_out", {data_out_2, data_out_1, data_out_0}, 0);
        rst = 1'b0;

        // Port 0, len 5, read 2 cycles after valid_out_0.
        build_pkt(5, 0, 8'h01, 0);
        check("model header len5/addr0", tx_q[0], 8'h14);
        check("model parity len5", tx_q[6], 8'h15);
        check("model size len5", tx_q.size(), 7);
        fork
            send_tx();
            begin
                wait_valid(0);
                repeat (2) @(negedge clk);
                read_en_0 = 1'b1;
            end
        join
        wait_drained(0);
        read_en_0 = 1'b0;
        @(negedge clk);
        check("len5 err", err, 0);
        check("len5 valid_out_0 after drain", valid_out_0, 0);

        // Port 1, len 20: reads start late so the queue fills and stalls.
        build_pkt(20, 1, 8'h40, 0);
        check("model header len20/addr1", tx_q[0], 8'h51);
        check("model size len20", tx_q.size(), 22);
        fork
            send_tx();
            begin
                wait_valid(1);
                run = 0; maxrun = 0;
                for (int c = 0; c < 40; c++) begin
                    if (c == 20) read_en_1 = 1'b1;
                    run = busy ? run + 1 : 0;
                    if (run > maxrun) maxrun = run;
                    @(negedge clk);
                end
            end
        join
        check("len20 full stall seen (busy run>=4)", maxrun >= 4, 1);
        wait_drained(1);
        read_en_1 = 1'b0;
        @(negedge clk);
        check("len20 err", err, 0);
        check("len20 busy idle", busy, 0);
        check("len20 valid_out_1 after drain", valid_out_1, 0);

        // Port 2, len 3, corrupted parity; the next packet clears err.
        build_pkt(3, 2, 8'h10, 1);
        check("model corrupt parity", tx_q[4], 8'h1C);
        read_en_2 = 1'b1;
        send_tx();
        wait_drained(2);
        repeat (2) @(negedge clk);
        check("bad parity err", err, 1);
        read_en_2 = 1'b0;
        build_pkt(2, 0, 8'h33, 0);
        read_en_0 = 1'b1;
        repeat (3) @(negedge clk);
        check("err held until next packet", err, 1);
        send_tx();
        wait_drained(0);
        read_en_0 = 1'b0;
        check("err cleared by next packet", err, 0);

        // Port 2 never read: flushed after SOFT_RST_CYCLES idle cycles.
        build_pkt(2, 2, 8'h70, 0);
        fork
            send_tx();
            begin
                wait_valid(2);
                hi = 0;
                while (valid_out_2 && hi < 100) begin
                    hi++;
                    @(negedge clk);
                end
            end
        join
        check("soft flush idle cycles", hi, 30);
        check("valid_out_2 after flush", valid_out_2, 0);
        check("busy after flush", busy, 0);
        exp_q[2].delete();

        // Two packets to port 0: the second waits until port 0 is drained.
        build_pkt(3, 0, 8'h21, 0);
        send_tx();
        build_pkt(2, 0, 8'hA0, 0);
        fork
            send_tx();
            begin
                repeat (6) @(negedge clk);
                check("wait_till_empty busy", busy, 1);
                check("wait_till_empty valid_out_0", valid_out_0, 1);
                read_en_0 = 1'b1;
            end
        join
        wait_drained(0);
        read_en_0 = 1'b0;
        check("back-to-back err", err, 0);

        // Header with address 3 is ignored.
        @(negedge clk);
        data_in = 8'h03; pkt_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h00; pkt_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("addr3 no valid_out", {valid_out_2, valid_out_1, valid_out_0}, 0);
            check("addr3 busy", busy, 0);
            @(negedge clk);
        end

        // Set err, then reset in the middle of a payload.
        build_pkt(1, 2, 8'h09, 1);
        read_en_2 = 1'b1;
        send_tx();
        wait_drained(2);
        read_en_2 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset err", err, 1);
        build_pkt(10, 1, 8'h55, 0);
        @(negedge clk); data_in = tx_q[0]; pkt_valid = 1'b1;
        @(negedge clk); data_in = tx_q[1];
        @(negedge clk);
        @(negedge clk); data_in = tx_q[2];
        check("pre-reset valid_out_1", valid_out_1, 1);
        @(negedge clk);
        rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        @(negedge clk);
        check("mid-packet reset valid_out", {valid_out_2, valid_out_1, valid_out_0}, 0);
        check("mid-packet reset busy", busy, 0);
        check("mid-packet reset err", err, 0);
        check("mid-packet reset data_out", {data_out_2, data_out_1, data_out_0}, 0);
        rst = 1'b0;

        // Traffic resumes after reset.
        build_pkt(1, 0, 8'hC3, 0);
        read_en_0 = 1'b1;
        send_tx();
        wait_drained(0);
        read_en_0 = 1'b0;
        repeat (2) @(negedge clk);
        check("post-reset err", err, 0);
        check("post-reset valid_out_0", valid_out_0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
